elastic_reg_queue: RTL and testbench
====================================

Name: elastic_reg_queue

Overview:
- Parametrised successor to the single-slot elastic register in the multi-cycle base library.
- Holds a committed value that is always readable on OUT_READ.
- Writes that arrive before the reader has consumed the current value are queued in a DEPTH-entry pending FIFO instead of stalling after one entry.
- Used wherever a producer may issue several register updates per consumer read, e.g. a multi-cycle port partitioned across clock-ratio boundaries.

Parameters:
WIDTH, 8, data width in bits; must be >= 1.
DEPTH, 4, number of pending-write entries; must be >= 1, any integer, not restricted to powers of two.
INIT, 0, committed value after reset.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  reset; asynchronous, active-high.
IN_WRITE  input  WIDTH  write data.
IN_WRITE_VALID  input  1  write data valid.
IN_WRITE_CONSUMED  output  1  write data accepted this cycle.
IN_EN_WRITE  input  1  write enable (1 = update, 0 = no-op token).
IN_EN_WRITE_VALID  input  1  enable token valid.
IN_EN_WRITE_CONSUMED  output  1  enable token accepted this cycle.
OUT_READ  output  WIDTH  committed value.
OUT_READ_VALID  output  1  constant 1.
OUT_READ_CONSUMED  input  1  reader consumes the current committed value this cycle.
PEND_COUNT  output  clog2(DEPTH+1)  number of queued pending writes.
FULL  output  1  PEND_COUNT == DEPTH.

Behaviour:
- Reset (RST high, asynchronous assert, synchronous-to-CLK release is the system's job):
  - committed register = INIT; PEND_COUNT = 0; read/write pointers = 0; FULL = 0.
  - Pending contents are discarded, including when reset asserts mid-operation.
  - OUT_READ = INIT immediately on assertion.
- Outputs:
  - OUT_READ = committed register; OUT_READ_VALID = 1 always.
- Write acceptance:
  - accept = IN_WRITE_VALID && IN_EN_WRITE_VALID && !FULL.
  - IN_WRITE_CONSUMED = IN_EN_WRITE_CONSUMED = accept.
  - accept is a function of registered count only; no combinational path from OUT_READ_CONSUMED to the CONSUMED outputs.
  - enq = accept && IN_EN_WRITE. accept with IN_EN_WRITE=0 consumes both tokens and changes no state.
- Per-edge update, with cons = OUT_READ_CONSUMED:
  - count==0, enq, cons: committed <= IN_WRITE (write-through); count stays 0.
  - count==0, enq, !cons: push IN_WRITE; count 0->1.
  - count>0, cons, !enq: committed <= head; pop; count-1.
  - count>0, cons, enq: committed <= head; pop; push IN_WRITE; count unchanged.
  - count>0, !cons, enq: push; count+1.
  - !cons and !enq, or count==0 and !enq: no change. A cons with nothing pending leaves committed unchanged.
- Ordering: strict FIFO. The committed value sequence equals the enq sequence; no write is lost or duplicated.
- Latency:
  - Write-through is visible on OUT_READ the cycle after the accepting edge.
  - A queued write becomes visible the cycle after the edge where it is at the head and cons=1.
- Pointers wrap at DEPTH-1 -> 0 by explicit compare, not by modulo-2^n overflow.
- FULL:
  - No accept while FULL, regardless of cons in the same cycle.
  - The freed slot is usable from the next cycle.
- DEPTH=1 reproduces the existing single-slot register behaviour exactly, except for the reset style.

Test Plan:
1. WIDTH=8, DEPTH=3, INIT=0x5A. Assert RST asynchronously between edges -> OUT_READ=0x5A immediately, PEND_COUNT=0, FULL=0, OUT_READ_VALID=1. After release with both valids high -> CONSUMED=1.
2. Write-through: count=0, IN_WRITE=0x11, EN=1, both valids=1, cons=1 -> next cycle OUT_READ=0x11, PEND_COUNT=0.
3. Fill and drain:
   - cons=0, writes 0x21, 0x22, 0x23 -> PEND_COUNT=3, FULL=1, OUT_READ=0x11.
   - Offer 0x24 -> CONSUMED=0, not queued.
   - cons=1 for three cycles, no writes -> OUT_READ 0x21, 0x22, 0x23 on consecutive cycles, PEND_COUNT 2,1,0.
   - Run for 10 fill/drain rounds to exercise pointer wrap.
4. Simultaneous: 0x31 pending, cons=1 with write 0x32 -> OUT_READ=0x31, PEND_COUNT=1. Next cycle cons=1 -> OUT_READ=0x32, PEND_COUNT=0.
5. Token gating:
   - Both valids=1, EN=0 -> CONSUMED=1, no state change.
   - IN_WRITE_VALID=0, EN=1 -> CONSUMED=0, no enqueue.
   - IN_EN_WRITE_VALID=0 -> CONSUMED=0.
6. Reset mid-operation: PEND_COUNT=2 with OUT_READ=0x41, assert RST -> OUT_READ=0x5A, PEND_COUNT=0. After release, first cons with no writes -> OUT_READ stays 0x5A.

Source files
------------

// File: rtl/elastic_reg_queue.sv
// -----------------------------------------------------------------------------
// elastic_reg_queue
//   Elastic register with a DEPTH-entry pending-write FIFO. A committed value
//   is always presented on OUT_READ. Producer writes that arrive before the
//   reader has consumed the current value are queued in order. Each reader
//   consume then promotes the oldest pending write into the committed register.
//
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   IN_WRITE[_VALID]      write data token           -> IN_WRITE_CONSUMED
//   IN_EN_WRITE[_VALID]   write enable token (0=nop) -> IN_EN_WRITE_CONSUMED
//   OUT_READ[_VALID]      committed value, valid is always 1
//   OUT_READ_CONSUMED     reader takes the committed value this cycle
//   PEND_COUNT, FULL      pending-queue occupancy / occupancy == DEPTH
// -----------------------------------------------------------------------------

// One pending-entry storage slot. Contents are not reset: entries are only
// meaningful while they are counted as pending, so the occupancy count alone
// discards them on reset.
module elastic_reg_queue_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) data_q <= d_i;
  end

  assign q_o = data_q;
endmodule

module elastic_reg_queue #(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           IN_WRITE,
  input  logic                       IN_WRITE_VALID,
  output logic                       IN_WRITE_CONSUMED,
  input  logic                       IN_EN_WRITE,
  input  logic                       IN_EN_WRITE_VALID,
  output logic                       IN_EN_WRITE_CONSUMED,
  output logic [WIDTH-1:0]           OUT_READ,
  output logic                       OUT_READ_VALID,
  input  logic                       OUT_READ_CONSUMED,
  output logic [$clog2(DEPTH+1)-1:0] PEND_COUNT,
  output logic                       FULL
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] commit_q, commit_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;

  logic [DEPTH-1:0][WIDTH-1:0] slot_q;
  logic [DEPTH-1:0]            slot_we;
  logic [WIDTH-1:0]            head;

  logic full, empty, accept, enq, cons, push, pop;

  // Pointers wrap by explicit compare so any DEPTH works, not only 2^n.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake: accept depends on the registered count only, so the reader's
  // consume never reaches the CONSUMED outputs combinationally. A slot freed by
  // a consume this cycle becomes usable on the next cycle.
  // ---------------------------------------------------------------------------
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  assign accept = IN_WRITE_VALID && IN_EN_WRITE_VALID && !full;
  assign enq    = accept && IN_EN_WRITE;
  assign cons   = OUT_READ_CONSUMED;

  // With nothing pending, a write that meets a consume goes straight into the
  // committed register and never touches the FIFO.
  assign push = enq && !(empty && cons);
  assign pop  = cons && !empty;

  assign IN_WRITE_CONSUMED    = accept;
  assign IN_EN_WRITE_CONSUMED = accept;
  assign OUT_READ             = commit_q;
  assign OUT_READ_VALID       = 1'b1;
  assign PEND_COUNT           = count_q;
  assign FULL                 = full;

  // ---------------------------------------------------------------------------
  // Pending storage: one slot instance per entry.
  // ---------------------------------------------------------------------------
  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_slot
      assign slot_we[i] = push && (wr_ptr_q == PW'(i));
      elastic_reg_queue_slot #(.WIDTH(WIDTH)) u_slot (
        .clk_i (CLK),
        .we_i  (slot_we[i]),
        .d_i   (IN_WRITE),
        .q_o   (slot_q[i])
      );
    end
  endgenerate

  assign head = slot_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    commit_d = commit_q;
    if (empty && enq && cons) commit_d = IN_WRITE;
    else if (pop)             commit_d = head;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
  end

  // push is impossible while full and pop is impossible while empty, so the
  // count stays within 0..DEPTH.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      commit_q <= INIT;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      commit_q <= commit_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end
endmodule

// File: tb/tb_elastic_reg_queue.sv
module tb_elastic_reg_queue;
  localparam int             WIDTH = 8;
  localparam int             DEPTH = 3;
  localparam logic [7:0]     INIT  = 8'h5A;
  localparam int             CW    = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] IN_WRITE = '0;
  logic             IN_WRITE_VALID = 1'b0;
  logic             IN_WRITE_CONSUMED;
  logic             IN_EN_WRITE = 1'b0;
  logic             IN_EN_WRITE_VALID = 1'b0;
  logic             IN_EN_WRITE_CONSUMED;
  logic [WIDTH-1:0] OUT_READ;
  logic             OUT_READ_VALID;
  logic             OUT_READ_CONSUMED = 1'b0;
  logic [CW-1:0]    PEND_COUNT;
  logic             FULL;

  elastic_reg_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT)) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .IN_WRITE             (IN_WRITE),
    .IN_WRITE_VALID       (IN_WRITE_VALID),
    .IN_WRITE_CONSUMED    (IN_WRITE_CONSUMED),
    .IN_EN_WRITE          (IN_EN_WRITE),
    .IN_EN_WRITE_VALID    (IN_EN_WRITE_VALID),
    .IN_EN_WRITE_CONSUMED (IN_EN_WRITE_CONSUMED),
    .OUT_READ             (OUT_READ),
    .OUT_READ_VALID       (OUT_READ_VALID),
    .OUT_READ_CONSUMED    (OUT_READ_CONSUMED),
    .PEND_COUNT           (PEND_COUNT),
    .FULL                 (FULL)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: committed value plus an ordered list of pending writes.
  logic [7:0] m_commit;
  logic [7:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_commit = INIT;
    m_q.delete();
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ":out"},   32'(OUT_READ),       32'(m_commit));
    chk({tag, ":cnt"},   32'(PEND_COUNT),     m_q.size());
    chk({tag, ":full"},  32'(FULL),           32'(m_q.size() == DEPTH));
    chk({tag, ":valid"}, 32'(OUT_READ_VALID), 32'd1);
  endtask

  // One cycle: drive at the falling edge, check the handshake, let the rising
  // edge happen, update the model, check registered state at the next fall.
  task automatic step(input bit wv, input bit ev, input bit en,
                      input logic [7:0] d, input bit cons, input string tag);
    bit acc, enq;
    IN_WRITE_VALID    = wv;
    IN_EN_WRITE_VALID = ev;
    IN_EN_WRITE       = en;
    IN_WRITE          = d;
    OUT_READ_CONSUMED = cons;
    #1;
    acc = wv && ev && (m_q.size() < DEPTH);
    enq = acc && en;
    chk({tag, ":wcons"}, 32'(IN_WRITE_CONSUMED),    32'(acc));
    chk({tag, ":econs"}, 32'(IN_EN_WRITE_CONSUMED), 32'(acc));
    @(posedge CLK);
    if (m_q.size() == 0) begin
      if (enq && cons) m_commit = d;
      else if (enq)    m_q.push_back(d);
    end else begin
      if (cons) m_commit = m_q.pop_front();
      if (enq)  m_q.push_back(d);
    end
    @(negedge CLK);
    chk_state(tag);
  endtask

  task automatic idle();
    IN_WRITE_VALID = 0; IN_EN_WRITE_VALID = 0; IN_EN_WRITE = 0; OUT_READ_CONSUMED = 0;
  endtask

  initial begin
    model_reset();
    // 1. asynchronous reset between edges
    #3 RST = 1'b1;
    #1;
    chk_state("rst");
    chk("rst:lit", 32'(OUT_READ), 32'h5A);
    @(negedge CLK);
    RST = 1'b0;
    step(1, 1, 0, 8'hEE, 0, "post_rst_nop");

    // 2. write-through
    step(1, 1, 1, 8'h11, 1, "wt");
    chk("wt:lit", 32'(OUT_READ), 32'h11);

    // 3. fill, blocked write, drain
    step(1, 1, 1, 8'h21, 0, "fill0");
    step(1, 1, 1, 8'h22, 0, "fill1");
    step(1, 1, 1, 8'h23, 0, "fill2");
    chk("fill:full", 32'(FULL), 32'd1);
    step(1, 1, 1, 8'h24, 1, "blocked");
    chk("blocked:out", 32'(OUT_READ), 32'h21);
    step(0, 0, 0, 8'h00, 1, "drain1");
    chk("drain1:out", 32'(OUT_READ), 32'h22);
    step(0, 0, 0, 8'h00, 1, "drain2");
    chk("drain2:out", 32'(OUT_READ), 32'h23);
    chk("drain2:cnt", 32'(PEND_COUNT), 32'd0);
    step(0, 0, 0, 8'h00, 1, "cons_empty");

    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < DEPTH; k++) step(1, 1, 1, 8'($urandom), 0, "round_fill");
      step(1, 1, 1, 8'($urandom), 0, "round_blk");
      for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 8'($urandom), 1, "round_drain");
    end

    // 4. simultaneous consume and write
    step(1, 1, 1, 8'h31, 0, "sim_push");
    step(1, 1, 1, 8'h32, 1, "sim_both");
    chk("sim_both:out", 32'(OUT_READ), 32'h31);
    chk("sim_both:cnt", 32'(PEND_COUNT), 32'd1);
    step(0, 0, 0, 8'h00, 1, "sim_pop");
    chk("sim_pop:out", 32'(OUT_READ), 32'h32);

    // 5. token gating
    step(1, 1, 0, 8'h99, 0, "gate_en0");
    step(0, 1, 1, 8'h98, 0, "gate_wv0");
    step(1, 0, 1, 8'h97, 0, "gate_ev0");
    chk("gate:cnt", 32'(PEND_COUNT), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
           8'($urandom), $urandom_range(0, 2) == 0, "rand");

    // 6. reset mid-operation
    while (m_q.size() != 0) step(0, 0, 0, 8'h00, 1, "pre6_drain");
    step(1, 1, 1, 8'h41, 1, "m6_wt");
    step(1, 1, 1, 8'h42, 0, "m6_p0");
    step(1, 1, 1, 8'h43, 0, "m6_p1");
    chk("m6:out", 32'(OUT_READ), 32'h41);
    chk("m6:cnt", 32'(PEND_COUNT), 32'd2);
    idle();
    #2 RST = 1'b1;
    #1;
    model_reset();
    chk_state("rst_mid");
    @(negedge CLK);
    RST = 1'b0;
    step(0, 0, 0, 8'h00, 1, "rst_cons");
    chk("rst_cons:lit", 32'(OUT_READ), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
